// File: rtl/adder_operand_sequencer.sv
// adder_operand_sequencer: valid/ready stage that feeds a slow combinational adder, waits for it to settle, then captures and presents the sum
module adder_operand_sequencer #(
    parameter int WIDTH         = 64,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic [WIDTH-1:0]     add_num1_o,
    output logic [WIDTH-1:0]     add_num2_o,
    input  logic [WIDTH-1:0]     add_sum_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [WIDTH-1:0]     sum_o,
    output logic                 carry_o,
    output logic [CNT_WIDTH-1:0] done_count_o
);
    localparam int CW = SETTLE_CYCLES > 1 ? $clog2(SETTLE_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    assign in_ready_o = state == IDLE;
    // accept operands, hold them until the adder settles, then capture and hand off the sum
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            add_num1_o   <= '0;
            add_num2_o   <= '0;
            sum_o        <= '0;
            carry_o      <= 1'b0;
            out_valid_o  <= 1'b0;
            done_count_o <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid_i) begin
                    add_num1_o <= a_i;
                    add_num2_o <= b_i;
                    cnt        <= CW'(SETTLE_CYCLES - 1);
                    state      <= SETTLE;
                end
                SETTLE: if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else begin
                    sum_o       <= add_sum_i;
                    carry_o     <= add_sum_i < add_num1_o;
                    out_valid_o <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: if (out_ready_i) begin
                    out_valid_o  <= 1'b0;
                    done_count_o <= done_count_o + 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_operand_sequencer.sv
// tb_adder_operand_sequencer: randomized self-checking bench with a plain-arithmetic reference model
module tb_adder_operand_sequencer;
    localparam int SC = 4;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic [63:0] add_num1;
    logic [63:0] add_num2;
    logic [63:0] add_sum;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] sum;
    logic        carry;
    logic [15:0] done_count;
    int          vectors = 0;
    int          miscompares = 0;
    int unsigned exp_cnt = 0;

    adder_operand_sequencer #(.WIDTH(64), .SETTLE_CYCLES(SC), .CNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .a_i(a), .b_i(b), .add_num1_o(add_num1), .add_num2_o(add_num2),
        .add_sum_i(add_sum), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .sum_o(sum), .carry_o(carry), .done_count_o(done_count)
    );

    assign add_sum = add_num1 + add_num2;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [63:0] x, input logic [63:0] y);
        logic [64:0] full;
        int          lat;
        int          tries;
        bit          hs;
        bit          r;
        full = {1'b0, x} + {1'b0, y};
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL accept_ready: got %b want 1", in_ready);
        end
        in_valid = 1'b1; a = x; b = y; out_ready = 1'b0;
        step();
        in_valid = 1'b0; a = {$urandom, $urandom}; b = {$urandom, $urandom};
        vectors++;
        if (add_num1 !== x || add_num2 !== y) begin
            miscompares++;
            $display("FAIL operands: got %h/%h want %h/%h", add_num1, add_num2, x, y);
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        vectors++;
        if (lat != SC) begin
            miscompares++;
            $display("FAIL latency: got %0d want %0d", lat, SC);
        end
        vectors++;
        if (sum !== full[63:0] || carry !== full[64]) begin
            miscompares++;
            $display("FAIL sum: got %h c=%b want %h c=%b", sum, carry, full[63:0], full[64]);
        end
        hs = 0;
        tries = 0;
        while (!hs) begin
            r = tries >= 8 ? 1'b1 : 1'($urandom_range(0, 1));
            out_ready = r;
            step();
            tries++;
            if (r) hs = 1;
            else begin
                vectors++;
                if (out_valid !== 1'b1 || sum !== full[63:0]) begin
                    miscompares++;
                    $display("FAIL hold: got v=%b %h want v=1 %h", out_valid, sum, full[63:0]);
                end
            end
        end
        out_ready = 1'b0;
        exp_cnt++;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || done_count !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL handoff: got v=%b rdy=%b cnt=%0d want v=0 rdy=1 cnt=%0d",
                     out_valid, in_ready, done_count, 16'(exp_cnt));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || carry !== 1'b0 ||
            add_num1 !== '0 || add_num2 !== '0 || done_count !== '0) begin
            miscompares++;
            $display("FAIL reset_init: rdy=%b v=%b sum=%h c=%b n1=%h n2=%h cnt=%0d want 1 0 0 0 0 0 0",
                     in_ready, out_valid, sum, carry, add_num1, add_num2, done_count);
        end
        step();
        #3 rst = 1'b0;
        exp_cnt = 0;
        step();
        run_txn(64'd9, 64'd4);
        in_valid = 1'b1; a = 64'd3; b = 64'd3;
        step();
        in_valid = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 || carry !== 1'b0 ||
            add_num1 !== '0 || add_num2 !== '0 || done_count !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: rdy=%b v=%b sum=%h c=%b n1=%h n2=%h cnt=%0d want 1 0 0 0 0 0 0",
                     in_ready, out_valid, sum, carry, add_num1, add_num2, done_count);
        end
        #2 rst = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic test_basic();
        run_txn(64'd1, 64'd1);
        vectors++;
        if (sum !== 64'd2 || carry !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_1p1: got %h c=%b want 2 c=0", sum, carry);
        end
    endtask

    task automatic test_carry();
        run_txn(64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        vectors++;
        if (sum !== 64'd0 || carry !== 1'b1) begin
            miscompares++;
            $display("FAIL carry_wrap: got %h c=%b want 0 c=1", sum, carry);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] x;
        logic [63:0] y;
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        in_valid = 1'b1; a = x; b = y; out_ready = 1'b0;
        step();
        for (int k = 0; k < SC; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            step();
        end
        for (int k = 0; k < 10; k++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== x + y ||
                add_num1 !== x || add_num2 !== y) begin
                miscompares++;
                $display("FAIL backpressure: v=%b rdy=%b sum=%h n1=%h n2=%h want 1 0 %h %h %h",
                         out_valid, in_ready, sum, add_num1, add_num2, x + y, x, y);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        exp_cnt++;
        vectors++;
        if (out_valid !== 1'b0 || add_num1 !== x || add_num2 !== y || done_count !== 16'(exp_cnt)) begin
            miscompares++;
            $display("FAIL backpressure_release: v=%b n1=%h n2=%h cnt=%0d want 0 %h %h %0d",
                     out_valid, add_num1, add_num2, done_count, x, y, 16'(exp_cnt));
        end
    endtask

    task automatic test_reset_mid_settle();
        in_valid = 1'b1; a = 64'd100; b = 64'd200;
        step();
        in_valid = 1'b0;
        step();
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || done_count !== '0 || in_ready !== 1'b1 || add_num1 !== '0) begin
            miscompares++;
            $display("FAIL reset_settle: v=%b cnt=%0d rdy=%b n1=%h want 0 0 1 0",
                     out_valid, done_count, in_ready, add_num1);
        end
        #2 rst = 1'b0;
        exp_cnt = 0;
        for (int k = 0; k < SC + 2; k++) begin
            step();
            vectors++;
            if (out_valid !== 1'b0 || done_count !== '0) begin
                miscompares++;
                $display("FAIL reset_discard: v=%b cnt=%0d want 0 0", out_valid, done_count);
            end
        end
        run_txn(64'd5, 64'd7);
        vectors++;
        if (sum !== 64'd12) begin
            miscompares++;
            $display("FAIL after_reset: got %0d want 12", sum);
        end
    endtask

    task automatic test_sweep();
        #3 rst = 1'b1;
        #3 rst = 1'b0;
        exp_cnt = 0;
        for (longint i = 1; i < 1000000; i *= 59)
            for (longint j = 1; j < 1000000; j *= 73)
                run_txn(64'(i), 64'(j));
        vectors++;
        if (done_count !== 16'd16) begin
            miscompares++;
            $display("FAIL sweep_count: got %0d want 16", done_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 3)) step();
            run_txn({$urandom, $urandom}, {$urandom, $urandom});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid_settle();
        test_sweep();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
